// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// | Module   : alu_pkg                                                       |
// | Purpose  : Shared definitions for the ALU operand sequencer: opcode      |
// |            values, default widths, FSM state encoding and the field      |
// |            positions inside the packed ALU result word.                  |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
package alu_pkg;

    // Default widths of the ALU interface
    localparam int DATA_W = 4;
    localparam int OP_W   = 3;
    localparam int RES_W  = 8;

    // ALU opcodes
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_NOT = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    // Sequencer FSM encoding
    localparam int         ST_W     = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Flag positions in the packed result {Zero, Carry, res[5:0]}
    localparam int ZERO_BIT  = 7;
    localparam int CARRY_BIT = 6;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// | Module   : alu_operand_sequencer                                         |
// | Purpose  : Issue stage for the combinational 4-bit ALU. Accepts          |
// |            {A,B,opcode} over valid/ready, drives the registered operand  |
// |            bus for SETTLE_CYC cycles, captures the packed ALU word and   |
// |            offers it downstream over valid/ready. Chained commands take  |
// |            A from the low nibble of the previous result.                 |
// | Config   : ALU_SEQ_OPCNT_EN - build the completed-transaction counter;   |
// |            when undefined op_count is tied to 8'h00.                     |
// | Ports    : clk, rst (async, active high), ena (global freeze)            |
// |            in_valid/in_ready/in_a/in_b/in_op/in_chain : command input    |
// |            alu_a/alu_b/alu_op -> ALU, alu_result <- ALU                   |
// |            out_valid/out_ready/out_result/out_div0  : result output      |
// |            busy (state != IDLE), op_count (completed transactions)       |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module alu_operand_sequencer #(
    parameter int DATA_W     = 4,
    parameter int OP_W       = 3,
    parameter int RES_W      = 8,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_op,
    input  logic              in_chain,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [RES_W-1:0]  alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_result,
    output logic              out_div0,
    output logic              busy,
    output logic [7:0]        op_count
);

    import alu_pkg::*;

    // Settle counter runs 0 .. SETTLE_CYC-1 while in ISSUE
    localparam int              CNT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SETTLE_CYC - 1);

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_div0_pend;
    logic [DATA_W-1:0] r_last_a;      // low nibble of last captured result
    logic              r_out_valid;
    logic [RES_W-1:0]  r_out_result;
    logic              r_out_div0;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_capture;
    logic              w_retire;
    logic              w_settle_done;
    logic [DATA_W-1:0] w_a_sel;
    logic              w_div0;

    assign w_settle_done = (r_cnt == c_cnt_last);
    assign w_a_sel       = in_chain ? r_last_a : in_a;
    assign w_div0        = (in_op == OP_W'(OP_DIV)) && (in_b == '0);

    // Next-state and handshake decode. Every event is qualified by ena so
    // that a frozen sequencer neither accepts nor retires anything.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_capture    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = ena;
                if (ena && in_valid) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ena && w_settle_done) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Retiring the held result frees the operand bus on the
                // same edge, so a waiting command is taken with no bubble.
                w_in_ready = ena & out_ready;
                if (ena && out_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = in_valid ? ST_ISSUE : ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_accept = w_in_ready & in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_div0_pend  <= 1'b0;
            r_last_a     <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_div0   <= 1'b0;
        end else if (ena) begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_alu_a     <= w_a_sel;
                r_alu_b     <= in_b;
                r_alu_op    <= in_op;
                r_div0_pend <= w_div0;
                r_cnt       <= '0;
            end else if (r_state == ST_ISSUE && !w_settle_done) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_capture) begin
                r_out_result <= alu_result;
                r_last_a     <= alu_result[DATA_W-1:0];
                r_out_div0   <= r_div0_pend;
                r_out_valid  <= 1'b1;
            end else if (w_retire) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_OPCNT_EN
    logic [7:0] r_op_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= 8'h00;
        end else if (ena && r_out_valid && out_ready) begin
            r_op_count <= r_op_count + 8'd1;
        end
    end

    assign op_count = r_op_count;
`else
    assign op_count = 8'h00;
`endif

    assign in_ready   = w_in_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_div0   = r_out_div0;
    assign busy       = (r_state != ST_IDLE);

endmodule : alu_operand_sequencer
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// | Module   : tb_alu_operand_sequencer                                      |
// | Purpose  : Directed self-checking bench for alu_operand_sequencer with a |
// |            behavioural 4-bit ALU on the operand bus (SETTLE_CYC = 1).    |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [2:0] in_op = '0;
    logic       in_chain = 1'b0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_result;
    logic       out_div0;
    logic       busy;
    logic [7:0] op_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(
        .DATA_W(4), .OP_W(3), .RES_W(8), .SETTLE_CYC(1)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_div0(out_div0),
        .busy(busy), .op_count(op_count)
    );

    // Behavioural ALU: {Zero, Carry, res[5:0]}
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        logic [5:0] r;
        logic       c;
        logic [4:0] s;
        logic [7:0] p;
        r = '0; c = 1'b0; s = '0; p = '0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = {2'b00, s[3:0]}; c = s[4]; end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; r = {2'b00, s[3:0]}; c = s[4]; end
            3'd2: begin p = {4'b0, a} * {4'b0, b}; r = p[5:0]; c = |p[7:6]; end
            3'd3: begin if (b != 4'd0) r = {2'b00, a / b}; end
            3'd4: r = {2'b00, a & b};
            3'd5: r = {2'b00, a | b};
            3'd6: r = {2'b00, ~a};
            default: r = {2'b00, a ^ b};
        endcase
        return {(r == 6'd0), c, r};
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one command, let it be accepted, drop in_valid, wait for capture
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic chain);
        in_a = a; in_b = b; in_op = op; in_chain = chain; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_chain = 1'b0;
        tick();
    endtask

    logic [7:0] exp_cnt1;
    logic [7:0] exp_cnt2;

    initial begin
`ifdef ALU_SEQ_OPCNT_EN
        exp_cnt1 = 8'd1;
        exp_cnt2 = 8'd2;
`else
        exp_cnt1 = 8'd0;
        exp_cnt2 = 8'd0;
`endif
        // ---------------- reset state
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);

        // ---------------- 1: ADD 9+8, one-cycle latency
        in_a = 4'd9; in_b = 4'd8; in_op = 3'd0; in_chain = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("add_issue_valid", 32'(out_valid), 32'd0);
        chk("add_issue_busy", 32'(busy), 32'd1);
        chk("add_alu_a", 32'(alu_a), 32'd9);
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_result", 32'(out_result), 32'h41);
        tick();
        chk("add_retired", 32'(out_valid), 32'd0);
        chk("add_alu_b_hold", 32'(alu_b), 32'd8);

        // ---------------- 2: DIV by zero, then SUB 3-3
        issue(4'd5, 4'd0, 3'd3, 1'b0);
        chk("div_result", 32'(out_result), 32'h80);
        chk("div_div0", 32'(out_div0), 32'd1);
        tick();
        issue(4'd3, 4'd3, 3'd1, 1'b0);
        chk("sub_result", 32'(out_result), 32'h80);
        chk("sub_div0", 32'(out_div0), 32'd0);
        tick();

        // ---------------- 3: chain ADD 3+2 then MUL by 3
        issue(4'd3, 4'd2, 3'd0, 1'b0);
        chk("chain_add", 32'(out_result), 32'h05);
        tick();
        in_a = 4'hF; in_b = 4'd3; in_op = 3'd2; in_chain = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_chain = 1'b0;
        chk("chain_alu_a", 32'(alu_a), 32'd5);
        tick();
        chk("chain_mul", 32'(out_result), 32'h0F);
        tick();

        // ---------------- 4: backpressure then zero-bubble chained accept
        out_ready = 1'b0;
        issue(4'd1, 4'd1, 3'd0, 1'b0);
        in_a = 4'hF; in_b = 4'd4; in_op = 3'd5; in_chain = 1'b1; in_valid = 1'b1;
        #1;
        chk("bp_in_ready0", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", 32'(out_result), 32'h02);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; in_chain = 1'b0;
        chk("bp_nobubble_busy", 32'(busy), 32'd1);
        chk("bp_nobubble_valid", 32'(out_valid), 32'd0);
        chk("bp_chain_a", 32'(alu_a), 32'd2);
        chk("bp_alu_op", 32'(alu_op), 32'd5);
        tick();
        chk("bp_or_result", 32'(out_result), 32'h06);
        tick();

        // ---------------- 5: reset pulse mid-ISSUE
        in_a = 4'd7; in_b = 4'd7; in_op = 3'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_alu_a", 32'(alu_a), 32'd0);
        chk("midrst_alu_b", 32'(alu_b), 32'd0);
        chk("midrst_alu_op", 32'(alu_op), 32'd0);
        chk("midrst_result", 32'(out_result), 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("midrst_no_emit", 32'(out_valid), 32'd0);

        // ---------------- 6a: 257 back-to-back transactions
        in_a = 4'd6; in_b = 4'd3; in_op = 3'd7; in_chain = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 514; i++) begin
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("cnt_idle", 32'(busy), 32'd0);
        chk("cnt_257", 32'(op_count), 32'(exp_cnt1));

        // ---------------- 6b: ena=0 for 3 cycles mid-ISSUE
        in_a = 4'd2; in_b = 4'd3; in_op = 3'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("freeze_valid", 32'(out_valid), 32'd0);
            chk("freeze_busy", 32'(busy), 32'd1);
        end
        ena = 1'b1;
        tick();
        chk("freeze_done_valid", 32'(out_valid), 32'd1);
        chk("freeze_done_result", 32'(out_result), 32'h05);
        ena = 1'b0;
        #1;
        chk("freeze_hold_ready", 32'(in_ready), 32'd0);
        tick();
        chk("freeze_hold_valid", 32'(out_valid), 32'd1);
        chk("freeze_hold_cnt", 32'(op_count), 32'(exp_cnt1));
        ena = 1'b1;
        tick();
        chk("freeze_retired", 32'(out_valid), 32'd0);
        chk("freeze_cnt", 32'(op_count), 32'(exp_cnt2));
        ena = 1'b0;
        #1;
        chk("idle_ena0_ready", 32'(in_ready), 32'd0);
        ena = 1'b1;
        #1;
        chk("idle_ena1_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_operand_sequencer
`default_nettype wire
